shift_add_mul: RTL and testbench

- Multi-cycle 32x32 unsigned multiplier returning the low 32 bits of the product. Computes one multiplier bit per clock.
- Sits directly upstream of, and wraps, the team's combinational 32-bit adder `Add`. Each clock it supplies `Add` with (accumulator, shifted multiplicand) as operands and registers `Add`'s `sum` back into the accumulator.
- Valid/ready handshake on both sides. One operation is in flight at a time.

---
 rtl/shift_add_mul.sv | 125 ++++++++++++
 tb/tb_shift_add_mul.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
// shift_add_mul: multi-cycle 32x32 unsigned shift-and-add multiplier that
// returns the low 32 bits of a*b, one multiplier bit per clock. The
// accumulation goes through the combinational adder Add. Handshakes are
// valid/ready on the input and output sides, and one operation is in flight
// at a time.
// Optional feature: define SHIFT_ADD_MUL_EARLY_EXIT_EN to finish as soon as
// the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | one multiplier bit consumed per cycle (busy=1)
// DONE  | product presented until downstream accepts (out_valid=1)

// Combinational 32-bit adder. It has no carry out.
module Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  assign sum = a + b;
endmodule

module shift_add_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy
);

  // Add is 32 bits wide, so any other width cannot work.
  if (WIDTH != 32) begin : g_width_check
    $error("shift_add_mul: WIDTH must be 32");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  Add u_add (
    .a   (acc),
    .b   (mcand),
    .sum (add_sum)
  );

  assign acc_nxt = mplier[0] ? add_sum : acc;

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain after this iteration's shift.
  assign last = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
  assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. The handshakes depend only on the registered state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load the operands on acceptance, then shift and add each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) product <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Testbench for shift_add_mul. It uses directed and random operand pairs.
// Expected products come from 64-bit arithmetic. Expected latency comes from
// the highest set bit of b.
module tb_shift_add_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] product;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_add_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] full;
    full = {32'd0, x} * {32'd0, y};
    return full[31:0];
  endfunction

  // Number of RUN cycles expected for multiplier y.
  function automatic int ref_lat(input logic [31:0] y);
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
    int m;
    m = 0;
    for (int i = 0; i < 32; i++) if (y[i]) m = i + 1;
    return (m < 1) ? 1 : m;
`else
    return 32;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // This task is entered just after an edge with the DUT in IDLE. It presents
  // (ta, tb) and measures the latency. It then holds out_ready low for `stall`
  // cycles before it completes the output handshake. If pre_next is set, it
  // presents a=7, b=7 during the stall and keeps it presented afterwards.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input int stall, input bit pre_next);
    logic [31:0] exp_p;
    int          exp_lat;
    int          edges;
    int          busy_cnt;
    exp_p   = ref_mul(ta, tb);
    exp_lat = ref_lat(tb);
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    edges    = 0;
    busy_cnt = 0;
    while (!out_valid && edges < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, ".latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({tag, ".product"}, product, exp_p);
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    if (stall > 0) begin
      if (pre_next) begin
        a = 32'd7; b = 32'd7; in_valid = 1'b1;
      end
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".hold_product"}, product, exp_p);
        chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".hold_busy"}, 32'(busy), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".product_kept"}, product, exp_p);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen_valid;

    // Check the values held during reset, then release reset at a negedge.
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.product", product, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic", 32'd3, 32'd5, 0, 1'b0);
    run_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("wrap", 32'h0001_0000, 32'h0001_0000, 0, 1'b0);

    // Backpressure, with the next operands waiting during the stall.
    run_op("bp", 32'd100, 32'd3, 5, 1'b1);
    run_op("bp_next", 32'd7, 32'd7, 0, 1'b0);

    // Two operations back to back with out_ready held high.
    run_op("b2b_0", 32'h0000_1234, 32'h0000_0010, 0, 1'b0);
    run_op("b2b_1", 32'd2, 32'h8000_0000, 0, 1'b0);

    run_op("b_zero", 32'hDEAD_BEEF, 32'd0, 0, 1'b0);

    // Assert reset in the middle of a RUN.
    a = 32'd9; b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.product", product, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    chk("midrst.no_valid", 32'(seen_valid), 32'd0);
    run_op("after_rst", 32'd9, 32'd9, 0, 1'b0);

    // Random operand pairs. Some b values are shortened to vary the early-exit latency.
    for (int k = 0; k < 10; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", k), ra, rb, $urandom_range(0, 2), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
